// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared constants and sequencer state type for the DA FIR core
package da_pkg;

    localparam int DA_NTAPS = 8;
    localparam int DA_BW    = 8;
    localparam int DA_ACC_W = 32;
    localparam int DA_LAT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERIAL,
        ST_DRAIN,
        ST_OUT
    } da_seq_state_t;

endpackage

// File: rtl/da_tap_line.sv
// rtl/da_tap_line.sv - NTAPS x BW tap delay line with flush and bit-plane select
module da_tap_line #(
    parameter int NTAPS = 8,
    parameter int BW    = 8,
    parameter int SEL_W = (BW > 1) ? $clog2(BW) : 1
) (
    input  logic             clk3,
    input  logic             reset,
    input  logic             shift,
    input  logic             flush,
    input  logic [BW-1:0]    din,
    input  logic [SEL_W-1:0] sel,
    output logic [NTAPS-1:0] plane
);

    logic [BW-1:0] taps [NTAPS];

    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
        end else if (shift) begin
            taps[0] <= din;
            for (int k = 1; k < NTAPS; k++) taps[k] <= taps[k-1];
        end
    end

    // plane[k] is bit 'sel' of tap k; tap0 holds the newest sample
    always_comb begin
        plane = '0;
        for (int k = 0; k < NTAPS; k++) plane[k] = taps[k][sel];
    end

endmodule

// File: rtl/da_bit_sequencer.sv
// rtl/da_bit_sequencer.sv - sample intake, bit-plane serializer and result capture for the DA FIR core
module da_bit_sequencer
    import da_pkg::*;
#(
    parameter int NTAPS  = DA_NTAPS,
    parameter int BW     = DA_BW,
    parameter int ACC_W  = DA_ACC_W,
    parameter int DA_LAT = da_pkg::DA_LAT
) (
    input  logic             clk3,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BW-1:0]    in_sample,
    input  logic             flush,
    output logic             da_clear,
    output logic             da_en,
    output logic [NTAPS-1:0] da_bits,
    output logic             da_last,
    input  logic [ACC_W-1:0] da_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy
);

    localparam int CNT_W = (BW > 1) ? $clog2(BW) : 1;
    localparam int DRN_W = $clog2(DA_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(BW - 1);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(BW - 2);
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DA_LAT);
    localparam logic [DRN_W-1:0] DRAIN_ONE  = DRN_W'(1);

    da_seq_state_t    state;
    logic [CNT_W-1:0] bit_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic [NTAPS-1:0] plane;
    logic             accept;
    logic             flush_taps;

    // flush wins over a simultaneous sample, so the sample is refused outright
    assign flush_taps = (state == ST_IDLE) && flush;
    assign accept     = (state == ST_IDLE) && in_valid && !flush;
    assign in_ready   = (state == ST_IDLE) && !flush;
    assign busy       = (state != ST_IDLE);
    assign da_bits    = da_en ? plane : '0;

    da_tap_line #(
        .NTAPS (NTAPS),
        .BW    (BW),
        .SEL_W (CNT_W)
    ) u_tap_line (
        .clk3  (clk3),
        .reset (reset),
        .shift (accept),
        .flush (flush_taps),
        .din   (in_sample),
        .sel   (bit_cnt),
        .plane (plane)
    );

    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            drain_cnt <= '0;
            da_clear  <= 1'b0;
            da_en     <= 1'b0;
            da_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            da_clear <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_SERIAL;
                        bit_cnt  <= '0;
                        da_clear <= 1'b1;
                        da_en    <= 1'b1;
                        da_last  <= (LAST_BIT == '0);
                    end
                end
                ST_SERIAL: begin
                    if (bit_cnt == LAST_BIT) begin
                        state     <= ST_DRAIN;
                        da_en     <= 1'b0;
                        da_last   <= 1'b0;
                        drain_cnt <= DRAIN_LOAD;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        da_last <= (bit_cnt == PRE_LAST);
                    end
                end
                ST_DRAIN: begin
                    // core result becomes valid DA_LAT cycles after the sign plane
                    if (drain_cnt == DRAIN_ONE) begin
                        state     <= ST_OUT;
                        drain_cnt <= '0;
                        out_data  <= da_sum;
                        out_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
